// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the transmit word scheduler.
package tx_sched_pkg;

   // Scheduler FSM states
   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   // Source indices used by the grant, rr_ptr and last_src
   localparam logic SRC_ST  = 1'b0;
   localparam logic SRC_RPT = 1'b1;

   // Filler pattern sent when the link has been idle long enough
   localparam logic [31:0] IDLE_WORD = 32'hA5C3_5A3C;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick.
// On a tie the grant goes to the source that did not win last (not rr_ptr).
module rr_pick2
   import tx_sched_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic rr_ptr,
   output logic gnt_idx,
   output logic gnt_valid
);

   // Pick a requester, alternating on ties
   always_comb begin
      gnt_valid = req0 | req1;
      gnt_idx   = SRC_ST;
      if (req0 && req1) begin
         gnt_idx = ~rr_ptr;
      end else if (req1) begin
         gnt_idx = SRC_RPT;
      end
   end

endmodule

// File: rtl/tx_word_sched.sv
// Round-robin scheduler sharing the 32-bit transmit path between the
// self-test result stream and the chip status report source.
// Optional idle fill is enabled by defining TX_SCHED_IDLE_FILL_EN.
module tx_word_sched
   import tx_sched_pkg::*;
#(
   parameter int WORD_W   = 32,
   parameter int BEATS    = 4,
   parameter int IDLE_GAP = 16
) (
   input  logic              div_8_clk,
   input  logic              rst_n,
   input  logic              st_valid,
   input  logic [WORD_W-1:0] st_data,
   output logic              st_ready,
   input  logic              rpt_valid,
   input  logic [WORD_W-1:0] rpt_data,
   output logic              rpt_ready,
   output logic              tx_out,
   output logic [WORD_W-1:0] data_out,
   output logic              busy,
   output logic              last_src
);

   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

   state_t              state_q, state_d;
   logic                tx_out_q, tx_out_d;
   logic [WORD_W-1:0]   data_out_q, data_out_d;
   logic                last_src_q, last_src_d;
   logic                rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                gnt_idx;
   logic                gnt_valid;
   logic                in_idle;
   logic                xfer;
   logic                fill_go;
   logic [WORD_W-1:0]   sel_data;

   rr_pick2 u_pick (
      .req0      (st_valid),
      .req1      (rpt_valid),
      .rr_ptr    (rr_ptr_q),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // Ready only in IDLE, only to the granted requester, never during reset
   assign in_idle   = (state_q == S_IDLE);
   assign st_ready  = rst_n & in_idle & gnt_valid & (gnt_idx == SRC_ST);
   assign rpt_ready = rst_n & in_idle & gnt_valid & (gnt_idx == SRC_RPT);
   assign xfer      = (st_valid & st_ready) | (rpt_valid & rpt_ready);
   assign sel_data  = (gnt_idx == SRC_RPT) ? rpt_data : st_data;

`ifdef TX_SCHED_IDLE_FILL_EN
   localparam int ICNT_W = $clog2(IDLE_GAP) + 1;
   localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(IDLE_GAP - 1);

   logic [ICNT_W-1:0] idle_cnt_q, idle_cnt_d;

   // A real request always beats the filler in the same cycle
   assign fill_go = in_idle & ~gnt_valid & (idle_cnt_q == ICNT_LAST);

   // Count quiet IDLE cycles; any request, any send or leaving IDLE restarts it
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (!in_idle || gnt_valid || fill_go) begin
         idle_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   // Idle counter register
   always_ff @(posedge div_8_clk) begin
      if (!rst_n) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`else
   // Without idle fill only requested words go out; IDLE_GAP has no role
   logic unused_idle_gap;
   assign fill_go         = 1'b0;
   assign unused_idle_gap = (IDLE_GAP != 0);
`endif

   // Next-state logic: arbitrate in IDLE, hold the word for BEATS cycles in SEND
   always_comb begin
      state_d    = state_q;
      tx_out_d   = 1'b0;
      data_out_d = data_out_q;
      last_src_d = last_src_q;
      rr_ptr_d   = rr_ptr_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               data_out_d = sel_data;
               last_src_d = gnt_idx;
               rr_ptr_d   = gnt_idx;
               tx_out_d   = 1'b1;
               cnt_d      = '0;
               state_d    = S_SEND;
            end else if (fill_go) begin
               // Filler word leaves last_src and rr_ptr untouched
               data_out_d = WORD_W'(IDLE_WORD);
               tx_out_d   = 1'b1;
               cnt_d      = '0;
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM and registered outputs
   always_ff @(posedge div_8_clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         tx_out_q   <= 1'b0;
         data_out_q <= '0;
         last_src_q <= SRC_ST;
         rr_ptr_q   <= SRC_RPT;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         tx_out_q   <= tx_out_d;
         data_out_q <= data_out_d;
         last_src_q <= last_src_d;
         rr_ptr_q   <= rr_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   assign tx_out   = tx_out_q;
   assign data_out = data_out_q;
   assign last_src = last_src_q;
   assign busy     = (state_q == S_SEND);

endmodule

// File: tb/tb_tx_word_sched.sv
// Scoreboard bench for tx_word_sched: stimulus pushes expected words,
// a monitor pops and compares on every tx_out strobe.
module tb_tx_word_sched;
   import tx_sched_pkg::*;

   localparam int BEATS = 4;

   logic        div_8_clk = 1'b0;
   logic        rst_n     = 1'b0;
   logic        st_valid  = 1'b0;
   logic [31:0] st_data   = '0;
   logic        rpt_valid = 1'b0;
   logic [31:0] rpt_data  = '0;
   logic        st_ready, rpt_ready, tx_out, busy, last_src;
   logic [31:0] data_out;

   tx_word_sched #(.WORD_W(32), .BEATS(BEATS), .IDLE_GAP(16)) dut (
      .div_8_clk (div_8_clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid),
      .st_data   (st_data),
      .st_ready  (st_ready),
      .rpt_valid (rpt_valid),
      .rpt_data  (rpt_data),
      .rpt_ready (rpt_ready),
      .tx_out    (tx_out),
      .data_out  (data_out),
      .busy      (busy),
      .last_src  (last_src)
   );

   always #5 div_8_clk = ~div_8_clk;

   typedef struct packed {
      logic [31:0] data;
      logic        src;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_e;
   int   total = 0;
   int   bad   = 0;
   bit   chk_spacing = 1'b0;

   int   mon_run = 0;
   bit   mon_abandon = 1'b0;
   bit   mon_first = 1'b1;
   int   mon_cyc = 0;
   int   mon_prev = 0;
   int   tx_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic s);
      exp_t e;
      e.data = d;
      e.src  = s;
      exp_q.push_back(e);
   endtask

   task automatic tick;
      @(posedge div_8_clk);
      #1;
   endtask

   // Monitor: pop/compare on tx_out, busy length, tx spacing, ready sanity
   initial begin
      forever begin
         @(negedge div_8_clk);
         mon_cyc++;
         if (tx_out) begin
            tx_cnt++;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got data_out=%h last_src=%0d, want nothing", data_out, last_src);
            end else begin
               exp_e = exp_q.pop_front();
               check("word_data", data_out, exp_e.data);
               check("word_src", {31'b0, last_src}, {31'b0, exp_e.src});
            end
            if (chk_spacing) begin
               if (!mon_first) check("tx_spacing", 32'(mon_cyc - mon_prev), 32'(BEATS + 1));
               mon_first = 1'b0;
            end
            mon_prev = mon_cyc;
         end
         if (!chk_spacing) mon_first = 1'b1;
         if (busy) begin
            mon_run++;
            if (!rst_n) mon_abandon = 1'b1;
         end else if (mon_run > 0) begin
            if (!mon_abandon) check("busy_len", 32'(mon_run), 32'(BEATS));
            mon_run = 0;
            mon_abandon = 1'b0;
         end
         if (st_valid && rpt_valid) check("one_ready", {31'b0, st_ready & rpt_ready}, 32'd0);
         if ((st_ready && !st_valid) || (rpt_ready && !rpt_valid)) begin
            total++;
            bad++;
            $display("FAIL ready_no_valid: got st_ready=%0d rpt_ready=%0d, want 0 without valid", st_ready, rpt_ready);
         end
      end
   end

   task automatic do_reset;
      rst_n     = 1'b0;
      st_valid  = 1'b0;
      rpt_valid = 1'b0;
      tick;
      tick;
      @(negedge div_8_clk);
      check("rst_tx_out", {31'b0, tx_out}, 32'd0);
      check("rst_data_out", data_out, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_last_src", {31'b0, last_src}, 32'd0);
      tick;
      rst_n = 1'b1;
   endtask

   task automatic wait_idle;
      bit ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge div_8_clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL wait_idle: got busy stuck high, want idle within 40 cycles");
      end
      tick;
   endtask

   // Hold the already-raised valids until the wanted number of handshakes
   task automatic pump(input int want_st, input int want_rpt);
      int n_st = 0;
      int n_rpt = 0;
      for (int c = 0; c < 100 && (n_st < want_st || n_rpt < want_rpt); c++) begin
         @(negedge div_8_clk);
         if (st_valid && st_ready) n_st++;
         if (rpt_valid && rpt_ready) n_rpt++;
         tick;
         if (n_st >= want_st) st_valid = 1'b0;
         if (n_rpt >= want_rpt) rpt_valid = 1'b0;
      end
      check("pump_st_count", 32'(n_st), 32'(want_st));
      check("pump_rpt_count", 32'(n_rpt), 32'(want_rpt));
   endtask

   initial begin
`ifdef TX_SCHED_IDLE_FILL_EN
      // Idle fill after 16 quiet cycles
      do_reset;
      push(32'hA5C3_5A3C, 1'b0);
      repeat (15) tick;
      @(negedge div_8_clk);
      check("fill_not_early", {31'b0, tx_out}, 32'd0);
      tick;
      @(negedge div_8_clk);
      check("fill_tx", {31'b0, tx_out}, 32'd1);
      wait_idle;
      // Self-test word in the 16th idle cycle beats the filler
      do_reset;
      repeat (15) tick;
      st_valid = 1'b1;
      st_data  = 32'hCAFE_0016;
      push(32'hCAFE_0016, 1'b0);
      @(negedge div_8_clk);
      check("fill_st_ready", {31'b0, st_ready}, 32'd1);
      tick;
      st_valid = 1'b0;
      @(negedge div_8_clk);
      check("fill_st_tx", {31'b0, tx_out}, 32'd1);
      wait_idle;
`endif

      // Single self-test word after reset
      do_reset;
      st_valid = 1'b1;
      st_data  = 32'h1234_5678;
      push(32'h1234_5678, 1'b0);
      @(negedge div_8_clk);
      check("t1_st_ready", {31'b0, st_ready}, 32'd1);
      tick;
      st_valid = 1'b0;
      @(negedge div_8_clk);
      check("t1_tx_latency", {31'b0, tx_out}, 32'd1);
      check("t1_busy", {31'b0, busy}, 32'd1);
      wait_idle;

      // Both sources continuously valid: st, rpt, st, rpt, st, rpt
      do_reset;
      st_data   = 32'hAAAA_0001;
      rpt_data  = 32'hBBBB_0002;
      for (int i = 0; i < 3; i++) begin
         push(32'hAAAA_0001, 1'b0);
         push(32'hBBBB_0002, 1'b1);
      end
      chk_spacing = 1'b1;
      st_valid    = 1'b1;
      rpt_valid   = 1'b1;
      pump(3, 3);
      wait_idle;
      chk_spacing = 1'b0;

      // Report word raised during SEND waits for IDLE and goes out once
      st_valid = 1'b1;
      st_data  = 32'h1111_0000;
      push(32'h1111_0000, 1'b0);
      push(32'h2222_0000, 1'b1);
      pump(1, 0);
      rpt_valid = 1'b1;
      rpt_data  = 32'h2222_0000;
      for (int i = 0; i < BEATS; i++) begin
         @(negedge div_8_clk);
         check("t3_busy", {31'b0, busy}, 32'd1);
         check("t3_rpt_held_off", {31'b0, rpt_ready}, 32'd0);
         tick;
      end
      @(negedge div_8_clk);
      check("t3_rpt_ready", {31'b0, rpt_ready}, 32'd1);
      tick;
      rpt_valid = 1'b0;
      wait_idle;

      // Reset on the 2nd SEND cycle abandons the word; tie then grants st
      st_valid = 1'b1;
      st_data  = 32'h3333_4444;
      push(32'h3333_4444, 1'b0);
      @(negedge div_8_clk);
      check("t4_accept", {31'b0, st_ready}, 32'd1);
      tick;
      st_valid = 1'b0;
      tick;
      rst_n     = 1'b0;
      st_valid  = 1'b1;
      st_data   = 32'h5555_6666;
      rpt_valid = 1'b1;
      rpt_data  = 32'h7777_8888;
      push(32'h5555_6666, 1'b0);
      push(32'h7777_8888, 1'b1);
      tick;
      @(negedge div_8_clk);
      check("t4_rst_busy", {31'b0, busy}, 32'd0);
      check("t4_rst_data_out", data_out, 32'd0);
      check("t4_rst_tx_out", {31'b0, tx_out}, 32'd0);
      check("t4_rst_last_src", {31'b0, last_src}, 32'd0);
      check("t4_rst_st_ready", {31'b0, st_ready}, 32'd0);
      check("t4_rst_rpt_ready", {31'b0, rpt_ready}, 32'd0);
      tick;
      rst_n = 1'b1;
      pump(1, 1);
      wait_idle;

`ifndef TX_SCHED_IDLE_FILL_EN
      // No idle fill: long quiet stretch emits nothing
      tx_cnt = 0;
      repeat (100) tick;
      check("no_fill_tx_count", 32'(tx_cnt), 32'd0);
`endif

      // Every expected word must have been transmitted
      for (int c = 0; c < 30 && exp_q.size() != 0; c++) tick;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tx_word_sched.md
# tx_word_sched

Round-robin scheduler that shares the 32-bit transmit path (32-to-8 word splitter feeding the serializer) between two word sources: the self-test result stream and a chip status report source. Runs in the `div_8_clk` domain between the word sources and the word-to-byte converter. Issues one `tx_out` start strobe per word and holds the word stable for the converter's full occupancy window.

## Interface
Parameters:
- `WORD_W`, 32, word width
- `BEATS`, 4, `div_8_clk` cycles the downstream converter needs per word (≥2)
- `IDLE_GAP`, 16, idle cycles before an idle-fill word is sent (used only with the macro below)

Ports:
- `div_8_clk` in 1: sole clock
- `rst_n` in 1: synchronous, active-low reset
- `st_valid` in 1: self-test word available
- `st_data` in WORD_W: self-test word
- `st_ready` out 1: self-test word accepted this cycle when `st_valid` is high
- `rpt_valid` in 1: report word available
- `rpt_data` in WORD_W: report word
- `rpt_ready` out 1: report word accepted this cycle when `rpt_valid` is high
- `tx_out` out 1: one-cycle start strobe to the converter
- `data_out` out WORD_W: word presented to the converter
- `busy` out 1: high while a word occupies the converter
- `last_src` out 1: source of the word on `data_out` (0 = self-test, 1 = report)

## Operation
- States: IDLE, SEND.
- IDLE: the grant goes to a requesting source. If both request, the grant goes to the source not equal to `rr_ptr`. `rr_ptr` resets to 1, so self-test wins the first tie.
- Ready is combinational: `st_ready` = (state==IDLE) & grant==0. `rpt_ready` = (state==IDLE) & grant==1. Ready is never asserted for a non-requesting source.
- A transfer occurs when valid & ready. On that edge:
  - `data_out` ← selected data
  - `last_src` ← grant
  - `rr_ptr` ← grant
  - `tx_out` ← 1
  - beat counter ← 0
  - state → SEND
- SEND:
  - `tx_out` is 0 after the first SEND cycle.
  - The counter increments each cycle.
  - When the counter reaches BEATS-1, the state returns to IDLE.
  - `data_out` holds for all SEND cycles.
- Sources must hold valid and data until ready. The block never drops or duplicates a word.
- Valid deasserted while in SEND has no effect.
- `busy` = (state==SEND).
- The counter is $clog2(BEATS) bits wide and never wraps past BEATS-1.

## Timing
- Reset values (synchronous, on an edge with `rst_n`=0): state IDLE, `tx_out` 0, `data_out` 0, `busy` 0, `last_src` 0, `rr_ptr` 1, counter 0, idle counter 0.
- Latency: accept edge → `tx_out` high in the following cycle, with `data_out` valid in the same cycle.
- `busy` is high for exactly BEATS cycles per word, starting in the `tx_out` cycle.
- Throughput: 1 word per BEATS+1 cycles. There is one IDLE arbitration cycle between words.
- Reset mid-SEND abandons the word. Outputs return to reset values on the next edge. Ready stays low during reset.
- Simultaneous valid from both sources in IDLE: exactly one ready is high.

## Configuration
Macro `TX_SCHED_IDLE_FILL_EN`.
- Defined:
  - An idle counter increments each IDLE cycle with no valid, and clears on any transfer or any valid.
  - When the idle counter reaches IDLE_GAP-1, the block loads `IDLE_WORD` (32'hA5C3_5A3C) and sends it as a normal word (`tx_out` pulse, BEATS-cycle SEND).
  - `last_src` and `rr_ptr` are unchanged by an idle word.
  - A valid source takes priority over idle fill in the same cycle.
- Undefined: there is no idle counter. The block emits only requested words.

## Structure
- Package `tx_sched_pkg`:
  - state enum (`S_IDLE`, `S_SEND`)
  - `SRC_ST`=0, `SRC_RPT`=1
  - `IDLE_WORD`
- Sub-module `rr_pick2`: combinational 2-way round-robin pick from two requests and `rr_ptr`; outputs the grant index and a grant-valid flag.

## Test plan
- Reset, then `st_valid`=1 with `st_data`=32'h1234_5678 → `st_ready` high 1 cycle; next cycle `tx_out`=1, `data_out`=32'h1234_5678, `last_src`=0; `busy` high 4 cycles.
- Both valid continuously (st 32'hAAAA_0001, rpt 32'hBBBB_0002) → words alternate st, rpt, st, …; `tx_out` pulses exactly 5 cycles apart.
- `rpt_valid` held while the block is in SEND → `rpt_ready` stays low until the state returns to IDLE; the word is accepted once and transmitted once.
- `rst_n`=0 on the 2nd SEND cycle → the next edge gives `busy`=0, `data_out`=0, `tx_out`=0; after release, a tie grants self-test first.
- With `TX_SCHED_IDLE_FILL_EN`, no valid for 16 cycles after reset → `tx_out` pulses with `data_out`=32'hA5C3_5A3C; `st_valid` arriving in the 16th idle cycle → the self-test word is sent instead.
- Without the macro, 100 idle cycles → `tx_out` stays 0 throughout.
